// File: rtl/icache_assoc_pkg.sv
// icache_assoc shared types: FSM encoding, length code, field widths.
// Widths derive from the WAYS/SETS/LINE_HALFS geometry.
package icache_assoc_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_FILL
  } state_e;

  localparam logic [1:0] ILEN_32 = 2'b11;

  function automatic int off_w(input int halfs);
    return $clog2(halfs);
  endfunction

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int sets, input int halfs);
    return 31 - off_w(halfs) - idx_w(sets);
  endfunction

  function automatic int way_w(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/icache_assoc_if.sv
// icache_assoc bus: fetch request/response plus line refill port.
// slave is the cache side, master is the core/memory side.
interface icache_assoc_if;

  logic        req_valid;
  logic [31:0] req_addr;
  logic        flush;
  logic        resp_valid;
  logic [31:0] resp_inst;
  logic        resp_len;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;

  modport slave (
    input  req_valid, req_addr, flush,
    input  mem_req_ready, mem_rvalid, mem_rdata,
    output resp_valid, resp_inst, resp_len,
    output mem_req_valid, mem_req_addr
  );

  modport master (
    output req_valid, req_addr, flush,
    output mem_req_ready, mem_rvalid, mem_rdata,
    input  resp_valid, resp_inst, resp_len,
    input  mem_req_valid, mem_req_addr
  );

endinterface

// File: rtl/icache_assoc_way.sv
// icache_way: one way of data/tag/valid storage.
// Two combinational read ports, one line write port, bulk invalidate.
module icache_way
  import icache_assoc_pkg::*;
#(
  parameter int  SETS       = 32,
  parameter int  LINE_HALFS = 8,
  localparam int OW         = off_w(LINE_HALFS),
  localparam int IW         = idx_w(SETS),
  localparam int TW         = tag_w(SETS, LINE_HALFS)
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          inv,
  input  logic          vw_en,
  input  logic [IW-1:0] vw_idx,
  input  logic [TW-1:0] vw_tag,
  input  logic          vw_val,
  input  logic          dw_en,
  input  logic [IW-1:0] dw_idx,
  input  logic [OW-1:0] dw_off,
  input  logic [15:0]   dw_data,
  input  logic [IW-1:0] ra_idx,
  input  logic [OW-1:0] ra_off,
  output logic          ra_valid,
  output logic [TW-1:0] ra_tag,
  output logic [15:0]   ra_data,
  input  logic [IW-1:0] rb_idx,
  input  logic [OW-1:0] rb_off,
  output logic          rb_valid,
  output logic [TW-1:0] rb_tag,
  output logic [15:0]   rb_data
);

  logic [15:0]   data_q [SETS][LINE_HALFS];
  logic [TW-1:0] tag_q  [SETS];
  logic [SETS-1:0] valid_q;

  always_ff @(posedge clk_in) begin
    if (dw_en) data_q[dw_idx][dw_off] <= dw_data;
    if (vw_en) tag_q[vw_idx] <= vw_tag;
  end

  // invalidate beats any same-cycle install
  always_ff @(posedge clk_in) begin
    if (rst_in || inv) valid_q <= '0;
    else if (vw_en) valid_q[vw_idx] <= vw_val;
  end

  assign ra_valid = valid_q[ra_idx];
  assign ra_tag   = tag_q[ra_idx];
  assign ra_data  = data_q[ra_idx][ra_off];
  assign rb_valid = valid_q[rb_idx];
  assign rb_tag   = tag_q[rb_idx];
  assign rb_data  = data_q[rb_idx][rb_off];

endmodule

// File: rtl/icache_assoc.sv
// icache_assoc: set-associative RVC-aware instruction cache.
// Zero-latency hit lookup, one line refill in flight at a time.
module icache_assoc
  import icache_assoc_pkg::*;
#(
  parameter int WAYS       = 2,
  parameter int SETS       = 32,
  parameter int LINE_HALFS = 8
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          rdy_in,
  icache_assoc_if.slave bus
);

  localparam int OW = off_w(LINE_HALFS);
  localparam int IW = idx_w(SETS);
  localparam int TW = tag_w(SETS, LINE_HALFS);
  localparam int WW = way_w(WAYS);

  logic [31:0]   a1, a2, tgt_a;
  logic [OW-1:0] off1, off2;
  logic [IW-1:0] idx1, idx2, tgt_idx;
  logic [TW-1:0] tag1, tag2, tgt_tag;

  assign a1      = {bus.req_addr[31:1], 1'b0};
  assign a2      = a1 + 32'd2;
  assign off1    = a1[OW:1];
  assign off2    = a2[OW:1];
  assign idx1    = a1[OW+IW:OW+1];
  assign idx2    = a2[OW+IW:OW+1];
  assign tag1    = a1[31:OW+IW+1];
  assign tag2    = a2[31:OW+IW+1];

  state_e        state_q, state_d;
  logic [OW-1:0] beat_q, beat_d;
  logic [31:0]   addr_q, addr_d;
  logic [WW-1:0] vic_q, vic_d;
  logic          abort_q, abort_d;
  logic [WW-1:0] rr_q [SETS];

  logic [IW-1:0] f_idx;
  logic [TW-1:0] f_tag;
  assign f_idx = addr_q[OW+IW:OW+1];
  assign f_tag = addr_q[31:OW+IW+1];

  logic          inv, vw_en, vw_val, dw_en, rr_adv;
  logic [WW-1:0] vw_way;
  logic [IW-1:0] vw_idx;
  logic [TW-1:0] vw_tag;

  logic [WAYS-1:0] va, vb, h1w, h2w;
  logic [TW-1:0]   ta [WAYS];
  logic [TW-1:0]   tb [WAYS];
  logic [15:0]     da [WAYS];
  logic [15:0]     db [WAYS];

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    icache_way #(
      .SETS       (SETS),
      .LINE_HALFS (LINE_HALFS)
    ) u_way (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .inv      (inv),
      .vw_en    (vw_en && (vw_way == WW'(w))),
      .vw_idx   (vw_idx),
      .vw_tag   (vw_tag),
      .vw_val   (vw_val),
      .dw_en    (dw_en && (vic_q == WW'(w))),
      .dw_idx   (f_idx),
      .dw_off   (beat_q),
      .dw_data  (bus.mem_rdata),
      .ra_idx   (idx1),
      .ra_off   (off1),
      .ra_valid (va[w]),
      .ra_tag   (ta[w]),
      .ra_data  (da[w]),
      .rb_idx   (idx2),
      .rb_off   (off2),
      .rb_valid (vb[w]),
      .rb_tag   (tb[w]),
      .rb_data  (db[w])
    );
    assign h1w[w] = va[w] && (ta[w] == tag1);
    assign h2w[w] = vb[w] && (tb[w] == tag2);
  end

  logic        hit1, hit2, is32, resp_ok;
  logic [15:0] lo, hi;

  // a line lives in at most one way, so an OR-mux is exact
  always_comb begin
    lo = '0;
    hi = '0;
    for (int w = 0; w < WAYS; w++) begin
      lo = lo | (da[w] & {16{h1w[w]}});
      hi = hi | (db[w] & {16{h2w[w]}});
    end
  end

  assign hit1    = |h1w;
  assign hit2    = |h2w;
  assign is32    = (lo[1:0] == ILEN_32);
  assign resp_ok = !rst_in && bus.req_valid && hit1 && (!is32 || hit2);

  assign bus.resp_valid = resp_ok;
  assign bus.resp_len   = is32;
  assign bus.resp_inst  = !resp_ok ? '0 :
                          is32     ? {hi, lo} : {16'h0, lo};

  assign tgt_a   = hit1 ? a2 : a1;
  assign tgt_idx = tgt_a[OW+IW:OW+1];
  assign tgt_tag = tgt_a[31:OW+IW+1];

  logic [WAYS-1:0] vset;
  logic [WW-1:0]   vic;
  logic            found;

  assign vset = hit1 ? vb : va;

  always_comb begin
    vic   = rr_q[tgt_idx];
    found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!found && !vset[w]) begin
        vic   = WW'(w);
        found = 1'b1;
      end
    end
  end

  logic [WW-1:0] rr_cur, rr_nxt;
  assign rr_cur = rr_q[f_idx];
  assign rr_nxt = (rr_cur == WW'(WAYS - 1)) ? '0 : rr_cur + 1'b1;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    addr_d  = addr_q;
    vic_d   = vic_q;
    abort_d = abort_q;
    inv     = 1'b0;
    vw_en   = 1'b0;
    vw_val  = 1'b0;
    vw_way  = vic_q;
    vw_idx  = f_idx;
    vw_tag  = f_tag;
    dw_en   = 1'b0;
    rr_adv  = 1'b0;
    if (rdy_in && !rst_in) begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.flush) begin
            inv = 1'b1;
          end else if (bus.req_valid && !resp_ok) begin
            // victim is dropped now so its stale line cannot hit
            state_d = S_REQ;
            addr_d  = {tgt_a[31:OW+1], {(OW+1){1'b0}}};
            vic_d   = vic;
            abort_d = 1'b0;
            beat_d  = '0;
            vw_en   = 1'b1;
            vw_way  = vic;
            vw_idx  = tgt_idx;
            vw_tag  = tgt_tag;
          end
        end
        S_REQ: begin
          if (bus.flush) begin
            inv     = 1'b1;
            abort_d = 1'b1;
          end
          if (bus.mem_req_ready) state_d = S_FILL;
        end
        S_FILL: begin
          if (bus.flush) begin
            inv     = 1'b1;
            abort_d = 1'b1;
          end
          if (bus.mem_rvalid) begin
            dw_en  = 1'b1;
            beat_d = beat_q + 1'b1;
            if (beat_q == OW'(LINE_HALFS - 1)) begin
              state_d = S_IDLE;
              if (!abort_q && !bus.flush) begin
                vw_en  = 1'b1;
                vw_val = 1'b1;
                rr_adv = 1'b1;
              end
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      addr_q  <= '0;
      vic_q   <= '0;
      abort_q <= 1'b0;
      for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      addr_q  <= addr_d;
      vic_q   <= vic_d;
      abort_q <= abort_d;
      if (rr_adv) rr_q[f_idx] <= rr_nxt;
    end
  end

  assign bus.mem_req_valid = (state_q == S_REQ) && !rst_in;
  assign bus.mem_req_addr  = addr_q;

  logic unused_ok;
  assign unused_ok = ^{bus.req_addr[0], a2[0], tgt_a[OW:0]};

endmodule
